// File: rtl/wrapper_game_io_pkg.sv
// Shared constants and types for the board-side game I/O wrapper:
// default divider/debounce/colour settings, polarity constants and the
// per-key status bundle passed from each key channel to the wrapper.
package wrapper_game_io_pkg;

  // Default board timing and video bus shape.
  localparam int DEF_CLK_DIV         = 2;
  localparam int DEF_NUM_KEYS        = 4;
  localparam int DEF_DEBOUNCE_CYCLES = 16;
  localparam int DEF_RGB_W           = 3;

  // Polarity constants: value XORed onto the signal at the board boundary.
  localparam bit SYNC_POL_HIGH = 1'b0;
  localparam bit KEY_POL_HIGH  = 1'b0;

  // Counter width able to hold 0..n-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Per-key status: debounced level plus one-clk press/release pulses.
  typedef struct packed {
    logic level;
    logic press;
    logic rls;
  } key_evt_t;

endpackage

// File: rtl/wrapper_game_io_key_debounce.sv
// One board key: 2-FF synchroniser, debounce counter and press/release
// pending bits delivered as one-clk pulses on the cycle after `deliver`.
module wrapper_game_io_key_debounce
  import wrapper_game_io_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter bit KEY_ACTIVE_LOW  = KEY_POL_HIGH
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     key_raw,
  input  logic     deliver,
  output key_evt_t evt
);

  localparam int               CNT_W    = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q, sync_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             stable_q, stable_d;
  logic             press_pend_q, press_pend_d;
  logic             rel_pend_q, rel_pend_d;
  logic             press_q, press_d;
  logic             rel_q, rel_d;
  logic             rise, fall;

  // Next-state: synchronise (polarity folded in so reset 0 means released),
  // debounce with no partial credit, latch edges as pending, deliver on enable.
  always_comb begin
    sync_d   = {sync_q[0], key_raw ^ KEY_ACTIVE_LOW};
    stable_d = stable_q;
    cnt_d    = cnt_q;
    rise     = 1'b0;
    fall     = 1'b0;
    if (sync_q[1] == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      stable_d = ~stable_q;
      cnt_d    = '0;
      rise     = ~stable_q;
      fall     = stable_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
    // A new edge in the delivery cycle survives the clear.
    press_pend_d = rise | (press_pend_q & ~deliver);
    rel_pend_d   = fall | (rel_pend_q & ~deliver);
    press_d      = deliver & press_pend_q;
    rel_d        = deliver & rel_pend_q;
  end

  // State registers with synchronous reset to the released/idle state.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q       <= '0;
      cnt_q        <= '0;
      stable_q     <= 1'b0;
      press_pend_q <= 1'b0;
      rel_pend_q   <= 1'b0;
      press_q      <= 1'b0;
      rel_q        <= 1'b0;
    end else begin
      sync_q       <= sync_d;
      cnt_q        <= cnt_d;
      stable_q     <= stable_d;
      press_pend_q <= press_pend_d;
      rel_pend_q   <= rel_pend_d;
      press_q      <= press_d;
      rel_q        <= rel_d;
    end
  end

  assign evt = '{level: stable_q, press: press_q, rls: rel_q};

endmodule

// File: rtl/wrapper_game_io.sv
// Board-side wrapper for game cores: pixel clock-enable divider, debounced
// keys with press/release events aligned to the enable, and registered
// sync/colour outputs onto the board pins.
module wrapper_game_io
  import wrapper_game_io_pkg::*;
#(
  parameter int CLK_DIV         = DEF_CLK_DIV,
  parameter int NUM_KEYS        = DEF_NUM_KEYS,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter bit KEY_ACTIVE_LOW  = KEY_POL_HIGH,
  parameter int RGB_W           = DEF_RGB_W,
  parameter bit SYNC_INVERT     = SYNC_POL_HIGH
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_KEYS-1:0] keys,
  output logic                pix_ce,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  input  logic                game_hsync,
  input  logic                game_vsync,
  input  logic [RGB_W-1:0]    game_rgb,
  output logic                hsync,
  output logic                vsync,
  output logic [RGB_W-1:0]    rgb
);

  localparam int               DIV_W    = cnt_width(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic             div_hit;
  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic [RGB_W-1:0] rgb_q, rgb_d;
  key_evt_t         key_evt [NUM_KEYS];

  // Divider next-state: count 0..CLK_DIV-1 and wrap on the enable cycle.
  always_comb begin
    div_hit   = (div_cnt_q == DIV_LAST);
    div_cnt_d = div_hit ? '0 : div_cnt_q + 1'b1;
  end

  // Divider counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt_q <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
    end
  end

  // Masked by reset so CLK_DIV=1 stays quiet while reset is held.
  assign pix_ce = div_hit & ~reset;

  // Video next-state: capture on pix_ce only, blank colour during sync.
  always_comb begin
    hsync_d = hsync_q;
    vsync_d = vsync_q;
    rgb_d   = rgb_q;
    if (pix_ce) begin
      hsync_d = game_hsync ^ SYNC_INVERT;
      vsync_d = game_vsync ^ SYNC_INVERT;
      rgb_d   = (game_hsync | game_vsync) ? '0 : game_rgb;
    end
  end

  // Video output registers; reset drives syncs to their inactive level.
  always_ff @(posedge clk) begin
    if (reset) begin
      hsync_q <= SYNC_INVERT;
      vsync_q <= SYNC_INVERT;
      rgb_q   <= '0;
    end else begin
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      rgb_q   <= rgb_d;
    end
  end

  assign hsync = hsync_q;
  assign vsync = vsync_q;
  assign rgb   = rgb_q;

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
    wrapper_game_io_key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .KEY_ACTIVE_LOW (KEY_ACTIVE_LOW)
    ) u_key (
      .clk    (clk),
      .reset  (reset),
      .key_raw(keys[g]),
      .deliver(pix_ce),
      .evt    (key_evt[g])
    );
  end

  // Unpack per-key status into the flat key buses.
  always_comb begin
    key_level   = '0;
    key_press   = '0;
    key_release = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      key_level[i]   = key_evt[i].level;
      key_press[i]   = key_evt[i].press;
      key_release[i] = key_evt[i].rls;
    end
  end

endmodule

// File: tb/tb_wrapper_game_io.sv
// Scoreboard bench for wrapper_game_io: stimulus pushes expected output
// events (cycle stamp + value) per channel, a monitor pops them whenever a
// DUT output changes or pulses.
module tb_wrapper_game_io;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic rst;
  int   checks = 0;
  int   errors = 0;

  // u0: CLK_DIV=4, 4 keys, debounce 16, active-low board syncs
  logic [3:0] keys0, lvl0, prs0, rel0;
  logic       pix_ce0, gh0, gv0, hs0, vs0;
  logic [2:0] grgb0, rgb0;
  // u1: CLK_DIV=1
  logic       keys1, lvl1, prs1, rel1, pix_ce1, hs1, vs1;
  logic [2:0] rgb1;
  // u2: CLK_DIV=64, debounce 1, active-low keys
  logic [1:0] keys2, lvl2, prs2, rel2;
  logic       pix_ce2, hs2, vs2;
  logic [2:0] rgb2;

  wrapper_game_io #(.CLK_DIV(4), .NUM_KEYS(4), .DEBOUNCE_CYCLES(16), .KEY_ACTIVE_LOW(0),
                    .RGB_W(3), .SYNC_INVERT(1)) u0 (
    .clk(clk), .reset(rst), .keys(keys0), .pix_ce(pix_ce0), .key_level(lvl0),
    .key_press(prs0), .key_release(rel0), .game_hsync(gh0), .game_vsync(gv0),
    .game_rgb(grgb0), .hsync(hs0), .vsync(vs0), .rgb(rgb0));

  wrapper_game_io #(.CLK_DIV(1), .NUM_KEYS(1), .DEBOUNCE_CYCLES(16), .KEY_ACTIVE_LOW(0),
                    .RGB_W(3), .SYNC_INVERT(0)) u1 (
    .clk(clk), .reset(rst), .keys(keys1), .pix_ce(pix_ce1), .key_level(lvl1),
    .key_press(prs1), .key_release(rel1), .game_hsync(1'b0), .game_vsync(1'b0),
    .game_rgb(3'b000), .hsync(hs1), .vsync(vs1), .rgb(rgb1));

  wrapper_game_io #(.CLK_DIV(64), .NUM_KEYS(2), .DEBOUNCE_CYCLES(1), .KEY_ACTIVE_LOW(1),
                    .RGB_W(3), .SYNC_INVERT(0)) u2 (
    .clk(clk), .reset(rst), .keys(keys2), .pix_ce(pix_ce2), .key_level(lvl2),
    .key_press(prs2), .key_release(rel2), .game_hsync(1'b0), .game_vsync(1'b0),
    .game_rgb(3'b000), .hsync(hs2), .vsync(vs2), .rgb(rgb2));

  typedef struct {
    int         ch;
    int         cyc;
    logic [7:0] a;
    logic [7:0] b;
  } ev_t;
  ev_t sbq[$];

  // channels: 0 u0 pix_ce, 1 u0 level, 2 u0 events, 3 u0 video, 4 u2 level, 5 u2 events
  int ce_lo = 0;
  int ce_hi = -1;

  task automatic push(input int ch, input int c, input logic [7:0] a, input logic [7:0] b);
    ev_t e;
    e.ch = ch; e.cyc = c; e.a = a; e.b = b;
    sbq.push_back(e);
  endtask

  task automatic pop_cmp(input int ch, input string nm, input logic [7:0] a, input logic [7:0] b);
    int  idx;
    ev_t e;
    idx = -1;
    checks++;
    for (int i = 0; i < sbq.size(); i++)
      if (idx < 0 && sbq[i].ch == ch) idx = i;
    if (idx < 0) begin
      errors++;
      $display("FAIL %s unexpected output at cyc %0d a=%h b=%h, none required", nm, cyc, a, b);
    end else begin
      e = sbq[idx];
      sbq.delete(idx);
      if (e.cyc != cyc || e.a !== a || e.b !== b) begin
        errors++;
        $display("FAIL %s got cyc %0d a=%h b=%h, required cyc %0d a=%h b=%h",
                 nm, cyc, a, b, e.cyc, e.a, e.b);
      end
    end
  endtask

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h required %h", nm, act, exp);
    end
  endtask

  // First cycle p >= c on which a divider released after edge r asserts pix_ce.
  function automatic int next_ce(input int c, input int r, input int div);
    int p;
    p = c;
    while ((p - r) % div != div - 1) p++;
    return p;
  endfunction

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  logic [7:0] vid0;
  assign vid0 = {3'b000, hs0, vs0, rgb0};
  logic [3:0] prev_lvl0;
  logic [1:0] prev_lvl2;
  logic [7:0] prev_vid0;

  // Monitor: sample 1 time unit after each rising edge
  always @(posedge clk) begin
    #1;
    if (cyc >= 1) begin
      checks++;
      if (pix_ce1 !== !rst) begin
        errors++;
        $display("FAIL pix_ce_div1 cyc %0d got %b required %b", cyc, pix_ce1, !rst);
      end
    end
    if (cyc >= 3) begin
      if (pix_ce0 === 1'b1 && cyc >= ce_lo && cyc <= ce_hi) pop_cmp(0, "pix_ce0", 8'd1, 8'd0);
      if (lvl0 != prev_lvl0) pop_cmp(1, "key_level0", {4'b0, lvl0}, 8'd0);
      if ((prs0 | rel0) != 4'b0) pop_cmp(2, "key_evt0", {4'b0, prs0}, {4'b0, rel0});
      if (vid0 != prev_vid0) pop_cmp(3, "video0", vid0, 8'd0);
      if (lvl2 != prev_lvl2) pop_cmp(4, "key_level2", {6'b0, lvl2}, 8'd0);
      if ((prs2 | rel2) != 2'b0) pop_cmp(5, "key_evt2", {6'b0, prs2}, {6'b0, rel2});
    end
    prev_lvl0 = lvl0;
    prev_lvl2 = lvl2;
    prev_vid0 = vid0;
  end

  int R;
  int c;
  int p;

  initial begin
    rst = 1'b1; keys0 = 4'b0; keys1 = 1'b0; keys2 = 2'b11;
    gh0 = 1'b0; gv0 = 1'b0; grgb0 = 3'b000;

    // reset state after two reset edges
    wait_cyc(2);
    chk("rst_level0", {4'b0, lvl0}, 8'h00);
    chk("rst_press0", {4'b0, prs0}, 8'h00);
    chk("rst_release0", {4'b0, rel0}, 8'h00);
    chk("rst_pix_ce0", {7'b0, pix_ce0}, 8'h00);
    chk("rst_video0", vid0, 8'h18);
    chk("rst_level2", {6'b0, lvl2}, 8'h00);
    chk("rst_hsync2", {7'b0, hs2}, 8'h00);

    // divider: 3 reset cycles then 20 cycles, pix_ce on cycles 3,7,11,15,19
    wait_cyc(3);
    rst = 1'b0; R = 3;
    ce_lo = R; ce_hi = R + 19;
    for (int k = 0; k < 5; k++) push(0, R + 3 + 4 * k, 8'd1, 8'd0);

    // clean press on key 0
    wait_cyc(30);
    keys0[0] = 1'b1; c = cyc;
    push(1, c + 18, 8'h01, 8'h00);
    push(2, next_ce(c + 18, R, 4) + 1, 8'h01, 8'h00);

    // key 1 bounces every 5 clk for 60 clk, then held
    wait_cyc(70);
    for (int k = 0; k < 12; k++) begin
      keys0[1] = (k % 2 == 0);
      repeat (5) @(negedge clk);
    end
    keys0[1] = 1'b1; c = cyc;
    push(1, c + 18, 8'h03, 8'h00);
    push(2, next_ce(c + 18, R, 4) + 1, 8'h02, 8'h00);

    // release both keys together
    wait_cyc(c + 40);
    keys0 = 4'b0000; c = cyc;
    push(1, c + 18, 8'h00, 8'h00);
    push(2, next_ce(c + 18, R, 4) + 1, 8'h00, 8'h03);

    // video: hsync active with colour -> board hsync low, colour blanked
    wait_cyc(c + 40);
    gh0 = 1'b1; grgb0 = 3'b101; c = cyc;
    push(3, next_ce(c, R, 4) + 1, 8'h08, 8'h00);
    wait_cyc(c + 20);
    gh0 = 1'b0; c = cyc;
    push(3, next_ce(c, R, 4) + 1, 8'h1D, 8'h00);
    wait_cyc(c + 20);
    gv0 = 1'b1; grgb0 = 3'b110; c = cyc;
    push(3, next_ce(c, R, 4) + 1, 8'h10, 8'h00);
    wait_cyc(c + 20);
    gv0 = 1'b0; grgb0 = 3'b000; c = cyc;
    push(3, next_ce(c, R, 4) + 1, 8'h18, 8'h00);

    // u2: press and release inside one 64-cycle pix_ce period
    wait_cyc(c + 10);
    c = next_ce(cyc, R, 64) + 1;
    wait_cyc(c);
    keys2[0] = 1'b0;
    push(4, c + 3, 8'h01, 8'h00);
    wait_cyc(c + 3);
    keys2[0] = 1'b1;
    push(4, c + 6, 8'h00, 8'h00);
    push(5, next_ce(c + 6, R, 64) + 1, 8'h01, 8'h01);

    // key 2 held through a reset that lands mid-debounce
    wait_cyc(next_ce(c + 6, R, 64) + 10);
    keys0[2] = 1'b1; c = cyc;
    wait_cyc(c + 8);
    rst = 1'b1;
    wait_cyc(c + 9);
    chk("midrst_level0", {4'b0, lvl0}, 8'h00);
    chk("midrst_pix_ce0", {7'b0, pix_ce0}, 8'h00);
    chk("midrst_video0", vid0, 8'h18);
    wait_cyc(c + 10);
    rst = 1'b0; R = cyc;
    push(1, R + 18, 8'h04, 8'h00);
    p = next_ce(R + 18, R, 4);
    push(2, p + 1, 8'h04, 8'h00);

    // reset again with the level already high
    wait_cyc(p + 10);
    rst = 1'b1; c = cyc;
    push(1, c + 1, 8'h00, 8'h00);
    wait_cyc(c + 1);
    chk("rst2_level0", {4'b0, lvl0}, 8'h00);
    chk("rst2_press0", {4'b0, prs0}, 8'h00);
    wait_cyc(c + 2);
    rst = 1'b0; R = cyc;
    push(1, R + 18, 8'h04, 8'h00);
    push(2, next_ce(R + 18, R, 4) + 1, 8'h04, 8'h00);

    wait_cyc(R + 50);
    while (sbq.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL missing ch %0d required at cyc %0d a=%h b=%h",
               sbq[0].ch, sbq[0].cyc, sbq[0].a, sbq[0].b);
      sbq.delete(0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
